// File: rtl/lif_neuron_param.sv
// lif_neuron_param
// Parametrised leaky integrate-and-fire neuron. Accumulates N_IN weighted
// synaptic spikes into a saturating unsigned membrane potential, applies a
// subtractive or proportional leak, and fires when the updated potential
// reaches the threshold. After firing, a refractory period ignores input for
// REFRAC enabled cycles.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset (overrides en)
//   en          timestep enable; low freezes membrane, state and counter
//   spike_in    per-synapse spike, bit i selects weight i
//   weights     packed signed weights, weight i at [i*W_WIDTH +: W_WIDTH]
//   threshold   unsigned firing threshold
//   leak_val    mode 0: subtract amount; mode 1: low bits are the shift
//   membrane    registered membrane potential
//   spike_out   registered one-cycle spike pulse
//   refractory  high while in the REFRACTORY state
//   sat         one-cycle pulse when the update clamped at the maximum
//
// Handshake: there is no valid/ready flow control. Every enabled edge
// (en=1) is one timestep that consumes spike_in/weights/threshold/leak_val
// as sampled on that edge; en=0 edges consume nothing and hold state.
module lif_neuron_param #(
  parameter int N_IN      = 4,
  parameter int W_WIDTH   = 8,
  parameter int V_WIDTH   = 12,
  parameter int REFRAC    = 2,
  parameter int LEAK_MODE = 0,
  parameter int V_RESET   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [N_IN-1:0]           spike_in,
  input  logic [N_IN*W_WIDTH-1:0]   weights,
  input  logic [V_WIDTH-1:0]        threshold,
  input  logic [V_WIDTH-1:0]        leak_val,
  output logic [V_WIDTH-1:0]        membrane,
  output logic                      spike_out,
  output logic                      refractory,
  output logic                      sat
);

  // Full-width synaptic sum: N_IN signed weights can never overflow this.
  localparam int SW  = W_WIDTH + $clog2(N_IN) + 1;
  // Signed update width: covers the unsigned potential plus the sum.
  localparam int NW  = ((V_WIDTH > SW) ? V_WIDTH : SW) + 2;
  localparam int SHW = $clog2(V_WIDTH) + 1;
  localparam int RCW = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);

  localparam logic [V_WIDTH-1:0] V_MAX   = '1;
  localparam logic [V_WIDTH-1:0] V_RST   = V_WIDTH'(V_RESET);
  localparam logic [RCW-1:0]     CNT_INI = RCW'(REFRAC);

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [RCW-1:0]       cnt, cnt_nxt;
  logic [V_WIDTH-1:0]   membrane_nxt;
  logic                 spike_nxt;
  logic                 sat_nxt;

  logic signed [SW-1:0] syn_sum;
  logic [V_WIDTH-1:0]   leaked;
  logic [SHW-1:0]       shamt;
  logic signed [NW-1:0] upd;
  logic [V_WIDTH-1:0]   upd_clamped;
  logic                 upd_sat;

  // Weighted sum of active synapses, each weight sign-extended to SW bits.
  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike_in[i]) begin
        syn_sum = syn_sum + $signed({{(SW-W_WIDTH){weights[i*W_WIDTH+W_WIDTH-1]}},
                                     weights[i*W_WIDTH +: W_WIDTH]});
      end
    end
  end

  // Leak. In proportional mode a shift of 0 removes everything and a shift
  // of V_WIDTH or more shifts v to zero, leaving v unchanged.
  always_comb begin
    shamt  = leak_val[SHW-1:0];
    leaked = '0;
    if (LEAK_MODE == 0) begin
      leaked = (membrane > leak_val) ? (membrane - leak_val) : '0;
    end else begin
      leaked = membrane - (membrane >> shamt);
    end
  end

  // Signed update and clamp into [0, 2^V_WIDTH-1].
  always_comb begin
    upd = $signed({{(NW-V_WIDTH){1'b0}}, leaked})
        + $signed({{(NW-SW){syn_sum[SW-1]}}, syn_sum});
    upd_clamped = upd[V_WIDTH-1:0];
    upd_sat     = 1'b0;
    if (upd < 0) begin
      upd_clamped = '0;
    end else if (upd > $signed({{(NW-V_WIDTH){1'b0}}, V_MAX})) begin
      upd_clamped = V_MAX;
      upd_sat     = 1'b1;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    membrane_nxt = membrane;
    spike_nxt    = 1'b0;
    sat_nxt      = 1'b0;
    if (en) begin
      case (state)
        INTEGRATE: begin
          sat_nxt = upd_sat;
          // Threshold compares against the clamped new potential.
          if (upd_clamped >= threshold) begin
            spike_nxt    = 1'b1;
            membrane_nxt = V_RST;
            if (REFRAC > 0) begin
              state_nxt = REFRACTORY;
              cnt_nxt   = CNT_INI;
            end
          end else begin
            membrane_nxt = upd_clamped;
          end
        end
        REFRACTORY: begin
          membrane_nxt = V_RST;
          cnt_nxt      = cnt - 1'b1;
          if (cnt <= RCW'(1)) begin
            cnt_nxt   = '0;
            state_nxt = INTEGRATE;
          end
        end
        default: state_nxt = INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INTEGRATE;
      cnt       <= '0;
      membrane  <= '0;
      spike_out <= 1'b0;
      sat       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      membrane  <= membrane_nxt;
      spike_out <= spike_nxt;
      sat       <= sat_nxt;
    end
  end

  assign refractory = (state == REFRACTORY);

endmodule

// File: tb/tb_lif_neuron_param.sv
module tb_lif_neuron_param;

  localparam int N_IN = 4;
  localparam int WW   = 8;
  localparam int VW   = 12;

  logic              clk;
  logic              reset;
  logic              en;
  logic [N_IN-1:0]   spike_in;
  logic [N_IN*WW-1:0] weights;
  logic [VW-1:0]     threshold;
  logic [VW-1:0]     leak_val;

  // Subtractive-leak instance (default parameters).
  logic [VW-1:0] membrane;
  logic          spike_out, refractory, sat;
  // Proportional-leak instance, same inputs.
  logic [VW-1:0] membrane_p;
  logic          spike_out_p, refractory_p, sat_p;

  int n_checks;
  int n_fail;

  lif_neuron_param dut (
    .clk(clk), .reset(reset), .en(en), .spike_in(spike_in),
    .weights(weights), .threshold(threshold), .leak_val(leak_val),
    .membrane(membrane), .spike_out(spike_out),
    .refractory(refractory), .sat(sat)
  );

  lif_neuron_param #(.LEAK_MODE(1)) dut_p (
    .clk(clk), .reset(reset), .en(en), .spike_in(spike_in),
    .weights(weights), .threshold(threshold), .leak_val(leak_val),
    .membrane(membrane_p), .spike_out(spike_out_p),
    .refractory(refractory_p), .sat(sat_p)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int i, input int val);
    logic [WW-1:0] w;
    w = WW'(val);
    weights[i*WW +: WW] = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    en        = 1'b1;
    spike_in  = '0;
    weights   = '0;
    threshold = 12'd4095;
    leak_val  = '0;
  endtask

  task automatic test_reset();
    en = 1'b1;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      spike_in  = N_IN'($urandom_range(0, 15));
      weights   = $urandom;
      threshold = VW'($urandom_range(0, 4095));
      leak_val  = VW'($urandom_range(0, 4095));
      tick();
    end
    n_checks++;
    if (membrane !== 12'd0 || spike_out !== 1'b0 || refractory !== 1'b0 || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got mem=%0d spk=%b ref=%b sat=%b, want 0 0 0 0",
               membrane, spike_out, refractory, sat);
    end
    n_checks++;
    if (membrane_p !== 12'd0 || refractory_p !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_p: got mem=%0d ref=%b, want 0 0", membrane_p, refractory_p);
    end
    reset = 1'b0;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (membrane !== 12'd0 || spike_out !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got mem=%0d spk=%b, want 0 0", k, membrane, spike_out);
      end
    end
  endtask

  task automatic test_integrate_fire();
    int exp_m [8] = '{3, 5, 7, 9, 0, 0, 0, 3};
    logic exp_s [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    logic exp_r [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
    idle_inputs();
    do_reset();
    set_w(0, 3);
    spike_in  = 4'b0001;
    threshold = 12'd10;
    leak_val  = 12'd1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (membrane !== VW'(exp_m[k]) || spike_out !== exp_s[k] || refractory !== exp_r[k]) begin
        n_fail++;
        $display("FAIL integrate_fire edge %0d: got mem=%0d spk=%b ref=%b, want %0d %b %b",
                 k + 1, membrane, spike_out, refractory, exp_m[k], exp_s[k], exp_r[k]);
      end
    end
  endtask

  task automatic test_negative_multi();
    idle_inputs();
    do_reset();
    set_w(1, 5);
    spike_in = 4'b0010;
    tick();
    n_checks++;
    if (membrane !== 12'd5) begin
      n_fail++;
      $display("FAIL neg_load: got mem=%0d, want 5", membrane);
    end
    set_w(1, -8);
    tick();
    n_checks++;
    if (membrane !== 12'd0 || sat !== 1'b0 || spike_out !== 1'b0) begin
      n_fail++;
      $display("FAIL neg_clamp: got mem=%0d sat=%b spk=%b, want 0 0 0", membrane, sat, spike_out);
    end
    set_w(0, 4);
    set_w(2, -1);
    spike_in = 4'b0101;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (membrane !== VW'(3 * k)) begin
        n_fail++;
        $display("FAIL multi_input edge %0d: got mem=%0d, want %0d", k, membrane, 3 * k);
      end
    end
  endtask

  task automatic test_saturation();
    idle_inputs();
    do_reset();
    for (int i = 0; i < N_IN; i++) set_w(i, 127);
    spike_in = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (membrane !== VW'(508 * k) || sat !== 1'b0 || spike_out !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_ramp edge %0d: got mem=%0d sat=%b spk=%b, want %0d 0 0",
                 k, membrane, sat, spike_out, 508 * k);
      end
    end
    tick();
    n_checks++;
    if (membrane !== 12'd0 || sat !== 1'b1 || spike_out !== 1'b1 || refractory !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_fire: got mem=%0d sat=%b spk=%b ref=%b, want 0 1 1 1",
               membrane, sat, spike_out, refractory);
    end
    tick();
    n_checks++;
    if (sat !== 1'b0 || spike_out !== 1'b0 || membrane !== 12'd0) begin
      n_fail++;
      $display("FAIL sat_pulse_end: got sat=%b spk=%b mem=%0d, want 0 0 0", sat, spike_out, membrane);
    end
  endtask

  task automatic test_prop_leak();
    int exp_m [3] = '{75, 57, 43};
    idle_inputs();
    do_reset();
    set_w(0, 100);
    spike_in = 4'b0001;
    leak_val = 12'd12;  // shift >= V_WIDTH: no leak
    tick();
    n_checks++;
    if (membrane_p !== 12'd100) begin
      n_fail++;
      $display("FAIL prop_load: got mem=%0d, want 100", membrane_p);
    end
    spike_in = '0;
    leak_val = 12'd2;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (membrane_p !== VW'(exp_m[k])) begin
        n_fail++;
        $display("FAIL prop_leak edge %0d: got mem=%0d, want %0d", k + 1, membrane_p, exp_m[k]);
      end
    end
    leak_val = 12'd13;
    tick();
    n_checks++;
    if (membrane_p !== 12'd43) begin
      n_fail++;
      $display("FAIL prop_no_leak: got mem=%0d, want 43", membrane_p);
    end
    leak_val = 12'd0;
    tick();
    n_checks++;
    if (membrane_p !== 12'd0) begin
      n_fail++;
      $display("FAIL prop_shift0: got mem=%0d, want 0", membrane_p);
    end
  endtask

  task automatic test_threshold_zero();
    idle_inputs();
    do_reset();
    threshold = 12'd0;
    tick();
    n_checks++;
    if (spike_out !== 1'b1 || refractory !== 1'b1) begin
      n_fail++;
      $display("FAIL thresh_zero: got spk=%b ref=%b, want 1 1", spike_out, refractory);
    end
  endtask

  task automatic test_enable_and_refrac_reset();
    idle_inputs();
    do_reset();
    set_w(0, 3);
    spike_in  = 4'b0001;
    threshold = 12'd100;
    tick();
    tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (membrane !== 12'd6 || spike_out !== 1'b0 || refractory !== 1'b0) begin
        n_fail++;
        $display("FAIL en_hold cycle %0d: got mem=%0d spk=%b ref=%b, want 6 0 0",
                 k, membrane, spike_out, refractory);
      end
    end
    // Fire, then a disabled edge: pulse drops, refractory state holds.
    en = 1'b1;
    set_w(0, 120);
    tick();
    en = 1'b0;
    tick();
    n_checks++;
    if (spike_out !== 1'b0 || refractory !== 1'b1 || membrane !== 12'd0) begin
      n_fail++;
      $display("FAIL en_refrac_hold: got spk=%b ref=%b mem=%0d, want 0 1 0",
               spike_out, refractory, membrane);
    end
    // Reset on the first refractory cycle.
    en = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (refractory !== 1'b0 || membrane !== 12'd0 || spike_out !== 1'b0) begin
      n_fail++;
      $display("FAIL refrac_reset: got ref=%b mem=%0d spk=%b, want 0 0 0",
               refractory, membrane, spike_out);
    end
    set_w(0, 3);
    tick();
    n_checks++;
    if (membrane !== 12'd3 || refractory !== 1'b0) begin
      n_fail++;
      $display("FAIL refrac_reset_accept: got mem=%0d ref=%b, want 3 0", membrane, refractory);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_integrate_fire();
    test_negative_multi();
    test_saturation();
    test_prop_leak();
    test_threshold_zero();
    test_enable_and_refrac_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_neuron_param.md
Name: lif_neuron_param

Overview:
Parametrised leaky integrate-and-fire neuron, next generation of the single-input LIF cell. It accumulates N_IN weighted synaptic spike inputs into a saturating membrane potential, with programmable threshold, a selectable leak mode and a refractory period after each spike. It is the building block for the spiking-layer arrays and is instantiated once per neuron, driven by a shared clock and timestep enable.

Parameters:
N_IN, 4, number of synaptic inputs (>=1)
W_WIDTH, 8, width of each signed two's-complement synaptic weight
V_WIDTH, 12, width of the unsigned membrane potential
REFRAC, 2, refractory length in enabled cycles (0 = none)
LEAK_MODE, 0, 0 = subtractive leak (v - leak_val), 1 = proportional leak (v - (v >> shift))
V_RESET, 0, potential loaded after a spike (must be < 2^V_WIDTH)

Ports:
clk  input  1  clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  timestep enable; low = freeze all state
spike_in  input  N_IN  per-synapse spike, bit i selects weight i
weights  input  N_IN*W_WIDTH  packed signed weights, weight i at [i*W_WIDTH +: W_WIDTH]
threshold  input  V_WIDTH  firing threshold, unsigned
leak_val  input  V_WIDTH  mode 0: subtract amount; mode 1: low $clog2(V_WIDTH)+1 bits are the shift amount
membrane  output  V_WIDTH  registered membrane potential
spike_out  output  1  registered one-cycle spike pulse
refractory  output  1  high while in REFRACTORY state
sat  output  1  one-cycle pulse: the update clamped at 2^V_WIDTH-1

Behaviour:
- Reset (sync, highest priority, overrides en): membrane=0, spike_out=0, sat=0, refractory=0, refrac_cnt=0, state=INTEGRATE. Reset in any state, including mid-refractory, returns to INTEGRATE on that edge.
- en=0: membrane, state and refrac_cnt hold; spike_out and sat are 0 on that edge.
- States: INTEGRATE, REFRACTORY. Both are registered; all outputs are registered.
- INTEGRATE, en=1, on each edge:
  - sum = signed sum of weights[i] over set spike_in[i]. Compute at full width: W_WIDTH + $clog2(N_IN) + 1 bits, no overflow.
  - leaked in mode 0: max(v - leak_val, 0).
  - leaked in mode 1: v - (v >> s). s = 0 gives 0. s >= V_WIDTH gives v, i.e. no leak.
  - next = leaked + sum, computed signed. Clamp below 0 to 0. Clamp above 2^V_WIDTH-1 to max; on that clamp, sat=1 for that edge.
  - If next >= threshold (compare on the clamped next, not the old v): spike_out=1, membrane=V_RESET. Then go to REFRACTORY with refrac_cnt=REFRAC, or stay in INTEGRATE if REFRAC=0.
  - Otherwise membrane=next and spike_out=0.
  - threshold=0 fires on every enabled INTEGRATE edge.
- Latency: spike_in sampled at edge t produces spike_out high in the cycle after edge t. spike_out is never high for two consecutive cycles when REFRAC>0.
- REFRACTORY, en=1:
  - spike_in ignored, membrane held at V_RESET, no leak, spike_out=0, refractory=1.
  - refrac_cnt decrements each enabled edge; on the edge where it reaches 0, go to INTEGRATE.
  - Result: exactly REFRAC enabled edges ignore input.
- refractory = (state == REFRACTORY).
- Simultaneous fire and sat: both pulse on the same edge.

Test Plan:
- Reset: assert reset 2 cycles with random inputs and en=1 -> membrane=0, spike_out=0, refractory=0, sat=0; deassert and stay idle -> membrane stays 0.
- Integrate/fire/refractory (defaults, w0=3, threshold=10, leak_val=1, spike_in=0001 held):
  - membrane 3,5,7,9, then spike_out=1 and membrane=0 on edge 5.
  - refractory=1 for 2 edges with membrane=0.
  - Then membrane 3 on edge 8.
- Negative/multi input:
  - v=5, spike_in=0010, w1=-8, leak_val=0 -> membrane=0, no sat, no spike.
  - spike_in=0101, w0=4, w2=-1 -> +3 per edge.
- Saturation: all weights=127, spike_in=1111, leak_val=0, threshold=4095 -> +508/edge, reaching 4064 on edge 8. Edge 9 clamps to 4095 with sat=1 and spike_out=1 on the same edge; membrane=V_RESET.
- Proportional leak: LEAK_MODE=1, v=100, leak shift=2, no input, threshold=4095 -> membrane 75, 57, 43. Shift 0 -> membrane 0 in one edge.
- en and mid-refractory reset:
  - en=0 for 3 cycles during integrate -> membrane/state unchanged, spike_out=0.
  - Reset asserted on the first refractory cycle -> next cycle INTEGRATE, membrane=0, refractory=0, input accepted immediately.
